// File: rtl/maxpool_serializer_pkg.sv
// Shared types and elaboration helpers for the max-pool output serializer.
package maxpool_ser_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } ser_state_e;

  // Number of serial slices per channel word.
  function automatic int unsigned cyc_of(input int unsigned bw_in, input int unsigned ser_bw);
    return bw_in / ser_bw;
  endfunction

  function automatic bit params_ok(input int unsigned bw_in, input int unsigned ser_bw,
                                   input int unsigned depth);
    return (ser_bw != 0) && (ser_bw <= bw_in) && ((bw_in % ser_bw) == 0) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/maxpool_serializer_if.sv
// Word-in / slice-out bundle between the pool, the serializer and the next layer.
interface maxpool_serializer_if #(
  parameter int unsigned NO_CH  = 10,
  parameter int unsigned BW_IN  = 4,
  parameter int unsigned SER_BW = 2
);
  logic                           vld_in;
  logic [NO_CH-1:0][BW_IN-1:0]    data_in;
  logic                           rdy_out;
  logic                           vld_out;
  logic [NO_CH-1:0][SER_BW-1:0]   data_out;
  logic                           sof_out;
  logic                           eow_out;
  logic                           ovf;

  modport master (
    output vld_in, data_in, rdy_out,
    input  vld_out, data_out, sof_out, eow_out, ovf
  );

  modport slave (
    input  vld_in, data_in, rdy_out,
    output vld_out, data_out, sof_out, eow_out, ovf
  );
endinterface

// File: rtl/maxpool_ser_fifo.sv
// Word FIFO; pointers carry a wrap bit so full and occupancy fall out of the difference.
module maxpool_ser_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 4,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic [Aw:0]      count
);

  logic [Aw:0]      wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];

  assign full  = (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]) && (wptr_q[Aw] != rptr_q[Aw]);
  assign count = wptr_q - rptr_q;
  assign rdata = mem_q[rptr_q[Aw-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (Aw+1)'(1);
      if (pop)  rptr_q <= rptr_q + (Aw+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[Aw-1:0]] <= wdata;
  end

endmodule

// File: rtl/maxpool_serializer.sv
// Buffers parallel pooled words and re-emits them LSB slice first, optionally as gap-free pairs.
module maxpool_serializer
  import maxpool_ser_pkg::*;
#(
  parameter int unsigned NO_CH  = 10,
  parameter int unsigned BW_IN  = 4,
  parameter int unsigned SER_BW = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PAIR   = 1
) (
  input logic                 clk,
  input logic                 rst,
  maxpool_serializer_if.slave bus
);

  localparam int unsigned Cyc    = cyc_of(BW_IN, SER_BW);
  localparam int unsigned SliceW = (Cyc > 1) ? $clog2(Cyc) : 1;
  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned Need   = (PAIR != 0) ? 2 : 1;

  typedef logic [NO_CH-1:0][BW_IN-1:0] word_t;

  if (!params_ok(BW_IN, SER_BW, DEPTH)) begin : g_param_check
    $error("maxpool_serializer: BW_IN must be a multiple of SER_BW, DEPTH a power of two >= 2");
  end

  ser_state_e        state_q, state_d;
  logic [SliceW-1:0] slice_q, slice_d;
  logic              pair_q, pair_d;
  word_t             sreg_q, sreg_d;
  logic              ovf_q;

  logic              push, pop, full, avail, vld;
  logic [CntW-1:0]   count;
  word_t             fifo_rdata;

  // No back-pressure to the pool: a word is taken if there is room now or a pop frees it.
  assign push  = bus.vld_in && (!full || pop);
  assign avail = count >= CntW'(Need);

  maxpool_ser_fifo #(
    .Width(NO_CH * BW_IN),
    .Depth(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(bus.data_in),
    .rdata(fifo_rdata),
    .full (full),
    .count(count)
  );

  always_comb begin
    state_d = state_q;
    slice_d = slice_q;
    pair_d  = pair_q;
    sreg_d  = sreg_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (avail) begin
          pop     = 1'b1;
          sreg_d  = fifo_rdata;
          slice_d = '0;
          pair_d  = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.rdy_out) begin
          if (slice_q == SliceW'(Cyc - 1)) begin
            // The partner of a pair was counted in before the first word left the FIFO.
            if ((PAIR != 0) && !pair_q) begin
              pop     = 1'b1;
              sreg_d  = fifo_rdata;
              slice_d = '0;
              pair_d  = 1'b1;
            end else if (avail) begin
              pop     = 1'b1;
              sreg_d  = fifo_rdata;
              slice_d = '0;
              pair_d  = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            slice_d = slice_q + SliceW'(1);
            for (int c = 0; c < NO_CH; c++) begin
              sreg_d[c] = sreg_q[c] >> SER_BW;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      slice_q <= '0;
      pair_q  <= 1'b0;
      sreg_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slice_q <= slice_d;
      pair_q  <= pair_d;
      sreg_q  <= sreg_d;
      if (bus.vld_in && !push) ovf_q <= 1'b1;
    end
  end

  assign vld         = (state_q == StShift);
  assign bus.vld_out = vld;
  assign bus.sof_out = vld && (slice_q == '0) && !pair_q;
  assign bus.eow_out = vld && (slice_q == SliceW'(Cyc - 1));
  assign bus.ovf     = ovf_q;

  always_comb begin
    bus.data_out = '0;
    for (int c = 0; c < NO_CH; c++) begin
      bus.data_out[c] = vld ? sreg_q[c][SER_BW-1:0] : '0;
    end
  end

endmodule
